pipe_stage_buffer: RTL and testbench
====================================

// Module: pipe_stage_buffer
// PURPOSE
//  Parametrised pipeline stage register for instruction + packed control bits
//  between CPU stages (IF/ID, ID/EX, ...). Adds valid/ready flow control, a
//  2-entry skid so upstream may run one cycle ahead of a stall, and a flush
//  that squashes in-flight entries into bubbles. Sits between adjacent stages.
// PARAMETERS
//  INSTR_W    16       instruction width
//  CTRL_W     10       packed control width {branchOp[1:0],aluOp[3:0],mux3sel,r0Write,regWrite,wEnable}
//  NOP_INSTR  16'h0000 instruction presented when out_valid=0 (bubble)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        upstream has an entry
//  in_ready   out  1        buffer can accept this cycle
//  in_instr   in   INSTR_W  upstream instruction
//  in_ctrl    in   CTRL_W   upstream control bits
//  flush      in   1        squash all held entries (branch taken / exception)
//  out_valid  out  1        downstream entry valid
//  out_ready  in   1        downstream accepts (0 = stall)
//  out_instr  out  INSTR_W  head instruction, NOP_INSTR when out_valid=0
//  out_ctrl   out  CTRL_W   head control, all-zero when out_valid=0
//  count      out  2        occupancy 0..2
// BEHAVIOUR
//  - Storage: main reg (head) + skid reg; states EMPTY, ONE, TWO (count 0/1/2).
//  - push = in_valid & in_ready; pop = out_valid & out_ready; sampled at clk edge.
//  - in_ready = (count != 2), registered-state based (no comb path from out_ready).
//  - out_valid = (count != 0); out_instr/out_ctrl = main reg when valid, else
//    NOP_INSTR / 0 (bubble gating is combinational on state; holds kill controls).
//  - Transitions:
//    EMPTY: push -> ONE (main<=in).
//    ONE:   push&pop -> ONE (main<=in); push only -> TWO (skid<=in);
//           pop only -> EMPTY; neither -> ONE, main held.
//    TWO:   pop -> ONE (main<=skid); no pop -> TWO, both held. push impossible.
//  - Latency: accepted entry appears at out on the next cycle (1 cycle).
//  - Throughput: 1 entry/cycle with out_ready held 1; order strictly FIFO.
//  - Stall: out_ready=0 holds main bit-exact every cycle; at most one further
//    entry accepted into skid, then in_ready=0 until a pop.
//  - flush=1: next state EMPTY regardless of push/pop; same-cycle push dropped;
//    same-cycle pop still counts as consumed by downstream. in_ready unaffected
//    in the flush cycle (value from current state).
//  - Priority: rst > flush > push/pop.
//  - Reset: count=0, out_valid=0, in_ready=1, out_instr=NOP_INSTR, out_ctrl=0;
//    main/skid regs cleared to NOP_INSTR/0. Reset mid-operation discards all entries.
//  - count never exceeds 2 nor underflows; no other wrap-around.
// TESTING
//  1 rst=1 two cycles -> out_valid=0, in_ready=1, count=0, out_instr=16'h0000, out_ctrl=0.
//  2 stream 16'h1111,16'h2222,16'h3333 (ctrl 10'h001,002,003) out_ready=1 ->
//    out in same order one cycle later, count stays 1, in_ready stays 1.
//  3 out_ready=0, push 16'hA000 then 16'hB000 -> count=2, in_ready=0, out_instr
//    holds 16'hA000; raise out_ready -> A000 then B000, count 2->1->0.
//  4 count=1 (head 16'h0101), push 16'h0202 with pop same cycle -> count=1,
//    out_instr=16'h0202 next cycle.
//  5 count=2, assert flush with in_valid=1 (16'hFFFF) -> next cycle count=0,
//    out_valid=0, out_instr=NOP_INSTR, out_ctrl=0; 16'hFFFF never emerges.
//  6 count=2, rst=1 with flush=0 -> next cycle reset values as in test 1;
//    subsequent push 16'h7777 emerges alone one cycle later.

Source files
------------

// File: rtl/pipe_stage_buffer_if.sv
// Handshake bundle for pipe_stage_buffer.
//   slave  : buffer side. It takes the upstream entry, flush and the downstream
//            ready, and drives in_ready, the head entry and the occupancy.
//   master : surrounding pipeline side, with the opposite directions.
// Signals:
//   in_valid/in_ready/in_instr/in_ctrl   upstream handshake and entry
//   flush                                squash all held entries
//   out_valid/out_ready/out_instr/out_ctrl downstream handshake and head entry
//   count                                occupancy 0..2
interface pipe_stage_buffer_if #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned CTRL_W  = 10
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [CTRL_W-1:0]  in_ctrl;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [CTRL_W-1:0]  out_ctrl;
    logic [1:0]         count;

    modport slave (
        input  in_valid, in_instr, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_instr, out_ctrl, count
    );

    modport master (
        output in_valid, in_instr, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_ctrl, count
    );
endinterface

// File: rtl/pipe_stage_buffer.sv
// Pipeline stage register with valid/ready flow control and a 2-entry skid.
// It holds the instruction and packed control bits between two CPU stages.
// Entry order is strictly FIFO. The main register is the head entry, and the
// skid register catches the one entry that upstream may send during a stall.
// A flush turns every held entry into a bubble.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   pipe_stage_buffer_if.slave. It carries the upstream and downstream
//         handshakes, flush and count.
module pipe_stage_buffer #(
    parameter int unsigned        INSTR_W   = 16,
    parameter int unsigned        CTRL_W    = 10,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_buffer_if.slave   bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state, state_nxt;
    logic [INSTR_W-1:0] main_instr, main_instr_nxt;
    logic [CTRL_W-1:0]  main_ctrl,  main_ctrl_nxt;
    logic [INSTR_W-1:0] skid_instr, skid_instr_nxt;
    logic [CTRL_W-1:0]  skid_ctrl,  skid_ctrl_nxt;
    logic               in_ready_i, out_valid_i;
    logic               push, pop;

    // in_ready and out_valid depend only on the registered state. This keeps
    // out_ready from having any combinational path through to in_ready.
    assign push = bus.in_valid & in_ready_i;
    assign pop  = out_valid_i & bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            main_instr <= NOP_INSTR;
            main_ctrl  <= '0;
            skid_instr <= NOP_INSTR;
            skid_ctrl  <= '0;
        end else begin
            state      <= state_nxt;
            main_instr <= main_instr_nxt;
            main_ctrl  <= main_ctrl_nxt;
            skid_instr <= skid_instr_nxt;
            skid_ctrl  <= skid_ctrl_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt      = state;
        main_instr_nxt = main_instr;
        main_ctrl_nxt  = main_ctrl;
        skid_instr_nxt = skid_instr;
        skid_ctrl_nxt  = skid_ctrl;
        if (bus.flush) begin
            // Any push in this cycle is dropped. A pop in this cycle has
            // already been taken by downstream, so nothing more is needed.
            state_nxt      = EMPTY;
            main_instr_nxt = NOP_INSTR;
            main_ctrl_nxt  = '0;
            skid_instr_nxt = NOP_INSTR;
            skid_ctrl_nxt  = '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt      = ONE;
                        main_instr_nxt = bus.in_instr;
                        main_ctrl_nxt  = bus.in_ctrl;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_instr_nxt = bus.in_instr;
                        main_ctrl_nxt  = bus.in_ctrl;
                    end else if (push) begin
                        state_nxt      = TWO;
                        skid_instr_nxt = bus.in_instr;
                        skid_ctrl_nxt  = bus.in_ctrl;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low in this state, so push cannot happen.
                    if (pop) begin
                        state_nxt      = ONE;
                        main_instr_nxt = skid_instr;
                        main_ctrl_nxt  = skid_ctrl;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Output logic. A bubble shows NOP_INSTR and zero control, so a held or
    // flushed entry cannot assert write enables downstream.
    always_comb begin
        in_ready_i    = (state != TWO);
        out_valid_i   = (state != EMPTY);
        bus.in_ready  = in_ready_i;
        bus.out_valid = out_valid_i;
        bus.out_instr = out_valid_i ? main_instr : NOP_INSTR;
        bus.out_ctrl  = out_valid_i ? main_ctrl : '0;
        unique case (state)
            EMPTY:   bus.count = 2'd0;
            ONE:     bus.count = 2'd1;
            TWO:     bus.count = 2'd2;
            default: bus.count = 2'd0;
        endcase
    end
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Testbench for pipe_stage_buffer. It runs directed scenarios and then random
// traffic. Every expectation comes from a queue-based FIFO model.
module tb_pipe_stage_buffer;
    localparam int unsigned IW = 16;
    localparam int unsigned CW = 10;
    localparam logic [IW-1:0] NOP = 16'h0000;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Each model entry is {instr, ctrl}.
    logic [IW+CW-1:0] q[$];

    always #5 clk = ~clk;

    pipe_stage_buffer_if #(.INSTR_W(IW), .CTRL_W(CW)) bus ();

    pipe_stage_buffer #(.INSTR_W(IW), .CTRL_W(CW), .NOP_INSTR(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the model occupancy and head entry.
    task automatic check_model();
        logic [IW-1:0] ei;
        logic [CW-1:0] ec;
        int unsigned n;
        n  = q.size();
        ei = (n != 0) ? q[0][IW+CW-1:CW] : NOP;
        ec = (n != 0) ? q[0][CW-1:0] : '0;
        chk("m_count",     32'(bus.count),     32'(n));
        chk("m_in_ready",  32'(bus.in_ready),  32'(n != 2));
        chk("m_out_valid", 32'(bus.out_valid), 32'(n != 0));
        chk("m_out_instr", 32'(bus.out_instr), 32'(ei));
        chk("m_out_ctrl",  32'(bus.out_ctrl),  32'(ec));
    endtask

    // Apply the inputs for one cycle. Outputs are checked mid-cycle, the model
    // advances on the clock edge, and the task returns 1 time unit after it.
    task automatic step(input logic v, input logic [IW-1:0] i, input logic [CW-1:0] c,
                        input logic ordy, input logic fl, input logic r);
        logic do_push, do_pop;
        bus.in_valid  = v;
        bus.in_instr  = i;
        bus.in_ctrl   = c;
        bus.out_ready = ordy;
        bus.flush     = fl;
        rst           = r;
        @(negedge clk);
        check_model();
        @(posedge clk);
        do_push = v && (q.size() < 2);
        do_pop  = ordy && (q.size() > 0);
        if (r || fl) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({i, c});
        end
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_ctrl = '0;
        bus.out_ready = 1'b0; bus.flush = 1'b0; rst = 1'b1;

        // Reset for two cycles
        @(posedge clk); #1;
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_count",     32'(bus.count),     32'd0);
        chk("rst_out_instr", 32'(bus.out_instr), 32'h0000);
        chk("rst_out_ctrl",  32'(bus.out_ctrl),  32'd0);

        // Streaming with downstream always ready
        step(1'b1, 16'h1111, 10'h001, 1'b1, 1'b0, 1'b0);
        chk("s1_instr", 32'(bus.out_instr), 32'h1111);
        chk("s1_count", 32'(bus.count), 32'd1);
        step(1'b1, 16'h2222, 10'h002, 1'b1, 1'b0, 1'b0);
        chk("s2_instr", 32'(bus.out_instr), 32'h2222);
        chk("s2_ctrl",  32'(bus.out_ctrl), 32'h002);
        step(1'b1, 16'h3333, 10'h003, 1'b1, 1'b0, 1'b0);
        chk("s3_instr", 32'(bus.out_instr), 32'h3333);
        chk("s3_ready", 32'(bus.in_ready), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("s4_count", 32'(bus.count), 32'd0);

        // Stall fills the skid, then drains in order
        step(1'b1, 16'hA000, 10'h0A0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hB000, 10'h0B0, 1'b0, 1'b0, 1'b0);
        chk("st_count", 32'(bus.count), 32'd2);
        chk("st_ready", 32'(bus.in_ready), 32'd0);
        chk("st_head",  32'(bus.out_instr), 32'hA000);
        step(1'b1, 16'hC000, 10'h0C0, 1'b0, 1'b0, 1'b0);
        chk("st_hold", 32'(bus.out_instr), 32'hA000);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("dr_instr", 32'(bus.out_instr), 32'hB000);
        chk("dr_count", 32'(bus.count), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("dr_empty", 32'(bus.count), 32'd0);

        // Push and pop in the same cycle while holding one entry
        step(1'b1, 16'h0101, 10'h011, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0202, 10'h022, 1'b1, 1'b0, 1'b0);
        chk("pp_count", 32'(bus.count), 32'd1);
        chk("pp_instr", 32'(bus.out_instr), 32'h0202);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Flush while full, with upstream offering an entry
        step(1'b1, 16'h0303, 10'h033, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0404, 10'h044, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hFFFF, 10'h3FF, 1'b0, 1'b1, 1'b0);
        chk("fl_count", 32'(bus.count), 32'd0);
        chk("fl_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_instr", 32'(bus.out_instr), 32'(NOP));
        chk("fl_ctrl",  32'(bus.out_ctrl), 32'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("fl_gone", 32'(bus.out_valid), 32'd0);

        // Reset while full
        step(1'b1, 16'h0505, 10'h055, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0606, 10'h066, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("mr_count", 32'(bus.count), 32'd0);
        chk("mr_ready", 32'(bus.in_ready), 32'd1);
        chk("mr_instr", 32'(bus.out_instr), 32'h0000);
        step(1'b1, 16'h7777, 10'h077, 1'b0, 1'b0, 1'b0);
        chk("mr_new",   32'(bus.out_instr), 32'h7777);
        chk("mr_alone", 32'(bus.count), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("mr_drain", 32'(bus.count), 32'd0);

        // Random traffic checked against the model
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), IW'($urandom), CW'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 49) == 0));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
